// File: rtl/mcm_fir3_accum.sv
// 3-tap FIR combiner for precomputed constant products: out[n] = 13x[n] + 25x[n-1] + 63x[n-2].
// Two-stage adder pipeline behind a valid/ready stream with full backpressure and a saturating sample counter.
module mcm_fir3_accum #(
    parameter int DW = 32,
    parameter int OW = 34,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] prod13,
    input  logic [DW-1:0] prod25,
    input  logic [DW-1:0] prod63,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_primed,
    output logic [CW-1:0] sample_cnt
);

    localparam int PW = DW + 1;
    localparam int NTAP = 2;

    logic          adv2;
    logic          accept;
    logic          drain;

    logic [DW-1:0] z1_reg;
    logic [DW-1:0] w_reg [NTAP];
    logic [DW-1:0] w_src [NTAP];

    logic [PW-1:0] p1_reg;
    logic [PW-1:0] p1_next;
    logic [DW-1:0] q1_reg;
    logic          v1_reg;

    logic [OW-1:0] out_data_reg;
    logic [OW-1:0] sum_next;
    logic          out_valid_reg;

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          primed_reg;

    // Stage 2 can take a value when it is empty or being emptied this cycle;
    // stage 1 can take a sample when it is empty or draining into stage 2.
    assign adv2     = !out_valid_reg || out_ready;
    assign in_ready = !clear && (!v1_reg || adv2);
    assign accept   = in_valid && in_ready;
    assign drain    = v1_reg && adv2;

    assign p1_next  = PW'(prod13) + PW'(z1_reg);
    assign sum_next = OW'(p1_reg) + OW'(q1_reg);

    // The 63x taps form a two-deep shift chain: w_reg[0] is w1, w_reg[1] is w2.
    generate
        for (genvar gi = 0; gi < NTAP; gi++) begin : g_tap
            if (gi == 0) begin : g_head
                assign w_src[gi] = prod63;
            end else begin : g_link
                assign w_src[gi] = w_reg[gi-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    w_reg[gi] <= '0;
                end else if (clear) begin
                    w_reg[gi] <= '0;
                end else if (accept) begin
                    w_reg[gi] <= w_src[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z1_reg <= '0;
        end else if (clear) begin
            z1_reg <= '0;
        end else if (accept) begin
            z1_reg <= prod25;
        end
    end

    // Stage 1 samples the delay line before it shifts, so p1/q1 see x[n-1] and x[n-2].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_reg <= '0;
            q1_reg <= '0;
            v1_reg <= 1'b0;
        end else if (clear) begin
            v1_reg <= 1'b0;
        end else if (accept) begin
            p1_reg <= p1_next;
            q1_reg <= w_reg[NTAP-1];
            v1_reg <= 1'b1;
        end else if (drain) begin
            v1_reg <= 1'b0;
        end
    end

    // On clear the output word is left in place but marked invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else if (clear) begin
            out_valid_reg <= 1'b0;
        end else if (drain) begin
            out_data_reg  <= sum_next;
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (accept && (cnt_reg != {CW{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            primed_reg <= 1'b0;
        end else if (clear) begin
            cnt_reg    <= '0;
            primed_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            primed_reg <= (cnt_next >= CW'(2));
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_primed = primed_reg;
    assign sample_cnt = cnt_reg;

endmodule

// File: tb/tb_mcm_fir3_accum.sv
// Directed bench for mcm_fir3_accum: a sample-history model predicts every output, count and flag,
// and per-test literal expectations pin the model's results.
module tb_mcm_fir3_accum;

    localparam int DW = 32;
    localparam int OW = 34;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] prod13 = '0;
    logic [DW-1:0] prod25 = '0;
    logic [DW-1:0] prod63 = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;
    logic          out_primed;
    logic [CW-1:0] sample_cnt;

    mcm_fir3_accum #(.DW(DW), .OW(OW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .prod13     (prod13),
        .prod25     (prod25),
        .prod63     (prod63),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_primed (out_primed),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: expected output = this sample's 13x plus the previous 25x and the 63x from two samples back.
    logic [63:0] exp_q [$];
    logic [63:0] obs_log [$];
    logic [63:0] m_h25, m_h63a, m_h63b;
    int          m_cnt;
    int          acc_total = 0;
    int          cyc = 0;
    int          first_acc = -1;
    int          first_ov = -1;
    logic        prev_stall = 1'b0;
    logic [OW-1:0] prev_data = '0;

    task automatic model_flush();
        exp_q.delete();
        m_h25 = 0; m_h63a = 0; m_h63b = 0;
        m_cnt = 0;
        prev_stall = 1'b0;
    endtask

    initial model_flush();

    // Inputs change at posedge+1, so everything is stable and meaningful at negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_flush();
        end else begin
            cyc++;
            check("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
            check("out_primed", 64'(out_primed), 64'(m_cnt >= 2));
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(prev_data));
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 64'(out_data), 64'hDEAD);
                end else begin
                    check("out_data", 64'(out_data), exp_q.pop_front());
                end
                obs_log.push_back(64'(out_data));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (clear) begin
                check("ready_in_clear", 64'(in_ready), 64'd0);
                model_flush();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(64'(prod13) + m_h25 + m_h63b);
                m_h63b = m_h63a;
                m_h63a = 64'(prod63);
                m_h25  = 64'(prod25);
                if (m_cnt < CMAX) m_cnt++;
                acc_total++;
                if (first_acc < 0) first_acc = cyc;
            end
        end
    end

    task automatic set_prod(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        prod13 = a; prod25 = b; prod63 = c;
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        set_prod(a, b, c);
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("send_accepted", 64'(got), 64'd1);
    endtask

    task automatic send_x(input int x);
        send(DW'(13 * x), DW'(25 * x), DW'(63 * x));
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic check_log(input string name, input int n, input logic [63:0] e0,
                             input logic [63:0] e1, input logic [63:0] e2, input logic [63:0] e3);
        logic [63:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({name, "_count"}, 64'(obs_log.size()), 64'(n));
        for (int i = 0; i < n && i < obs_log.size(); i++) check(name, obs_log[i], e[i]);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        $display("test %s: %0d outputs observed", name, obs_log.size());
    endtask

    initial begin
        int a0;
        logic hit;

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_primed", 64'(out_primed), 64'd0);
        check("rst_cnt", 64'(sample_cnt), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: x=1 stream, latency 2
        obs_log.delete();
        first_acc = -1; first_ov = -1;
        for (int i = 0; i < 3; i++) send_x(1);
        idle(4);
        check_log("t1_ramp", 3, 64'd13, 64'd38, 64'd101, 64'd0);
        check("t1_latency", 64'(first_ov - first_acc), 64'd2);
        check("t1_cnt", 64'(sample_cnt), 64'd3);
        check("t1_primed", 64'(out_primed), 64'd1);

        // 2: impulse response
        do_clear();
        obs_log.delete();
        send_x(1); send_x(0); send_x(0); send_x(0);
        idle(4);
        check_log("t2_impulse", 4, 64'd13, 64'd25, 64'd63, 64'd0);

        // 3: backpressure with continuous valid
        do_clear();
        obs_log.delete();
        out_ready = 1'b0;
        @(posedge clk); #1;
        send_x_hold: begin
            set_prod(DW'(26), DW'(50), DW'(126));
            in_valid = 1'b1;
        end
        a0 = acc_total;
        repeat (5) @(negedge clk);
        #1;
        check("t3_accepts_stalled", 64'(acc_total - a0), 64'd2);
        check("t3_in_ready_low", 64'(in_ready), 64'd0);
        check("t3_held_data", 64'(out_data), 64'd26);
        @(posedge clk); #1;
        out_ready = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (acc_total - a0 == 3) begin
                hit = 1'b1;
                break;
            end
        end
        check("t3_third_accept", 64'(hit), 64'd1);
        idle(5);
        check_log("t3_bp", 3, 64'd26, 64'd76, 64'd202, 64'd0);

        // 4: maximum products, no truncation
        do_clear();
        obs_log.delete();
        for (int i = 0; i < 3; i++) send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(4);
        check_log("t4_max", 3, 64'hFFFF_FFFF, 64'h1_FFFF_FFFE, 64'h2_FFFF_FFFD, 64'd0);

        // 5: clear with output pending and one sample in stage 1
        do_clear();
        obs_log.delete();
        out_ready = 1'b0;
        send_x(1); send_x(1);
        idle(1);
        @(negedge clk);
        check("t5_pending", 64'(out_valid), 64'd1);
        do_clear();
        @(negedge clk);
        check("t5_dropped_valid", 64'(out_valid), 64'd0);
        check("t5_cnt_zero", 64'(sample_cnt), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(DW'(39), DW'(75), DW'(189));
        idle(4);
        check_log("t5_after_clear", 1, 64'd39, 64'd0, 64'd0, 64'd0);
        check("t5_cnt_one", 64'(sample_cnt), 64'd1);
        check("t5_not_primed", 64'(out_primed), 64'd0);

        // 6: asynchronous reset between edges
        obs_log.delete();
        @(posedge clk); #1;
        set_prod(DW'(52), DW'(100), DW'(252));
        in_valid = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t6_streaming", 64'(out_valid), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 64'(out_valid), 64'd0);
        check("t6_async_data", 64'(out_data), 64'd0);
        check("t6_async_cnt", 64'(sample_cnt), 64'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        obs_log.delete();
        send_x(5);
        idle(4);
        check_log("t6_post_reset", 1, 64'd65, 64'd0, 64'd0, 64'd0);

        // 7: counter saturation
        do_clear();
        obs_log.delete();
        for (int i = 0; i < CMAX + 3; i++) send_x(1);
        idle(4);
        check("t7_cnt_sat", 64'(sample_cnt), 64'(CMAX));
        check("t7_primed", 64'(out_primed), 64'd1);
        check("t7_outputs", 64'(obs_log.size()), 64'(CMAX + 3));
        check("t7_last", obs_log[obs_log.size()-1], 64'd101);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mcm_fir3_accum.md
Name: mcm_fir3_accum

Overview:
- Registered 3-tap FIR combiner downstream of the shift-add constant-multiplier stage.
- Consumes the per-sample products 13·x, 25·x and 63·x and produces out[n] = 13·x[n] + 25·x[n-1] + 63·x[n-2].
- Uses a valid/ready stream with a 2-stage adder pipeline and full backpressure.
- Tracks sample count and delay-line warm-up.

Parameters:
- DW, 32, width of each incoming product (unsigned).
- OW, 34, output width; must be ≥ DW+2 so that no overflow is possible.
- CW, 16, width of the saturating sample counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of delay line, pipeline and counter.
- in_valid  in  1  product triple valid.
- in_ready  out  1  stage can accept a triple this cycle.
- prod13  in  DW  13·x[n].
- prod25  in  DW  25·x[n].
- prod63  in  DW  63·x[n].
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  OW  FIR result.
- out_primed  out  1  at least 2 samples accepted since reset/clear (delay line full).
- sample_cnt  out  CW  accepted samples since reset/clear, saturating.

Behaviour:
- Reset (rst_n low, async):
  - All registers cleared: out_valid=0, out_data=0, out_primed=0, sample_cnt=0.
  - Delay registers z1, w1, w2 = 0; stage-1 valid v1=0.
- Arithmetic: all unsigned, zero-extended to OW. Max result 3·(2^DW−1) fits in OW; no wrap.
- Delay line, updated only on accept (in_valid && in_ready):
  - z1 ← prod25.
  - w2 ← w1.
  - w1 ← prod63.
  - z1 holds 25·x[n-1]; w2 holds 63·x[n-2].
- Stage 1, loaded on accept:
  - p1 ← prod13 + z1, using pre-update z1 (DW+1 bits).
  - q1 ← w2, using pre-update w2.
  - v1 ← 1.
- Stage 2: out_data ← p1 + q1 and out_valid ← 1 when v1 && adv2.
- Stall and ready rules:
  - adv2 = !out_valid || out_ready.
  - in_ready = !clear && (!v1 || adv2). This is a combinational path from out_ready to in_ready.
  - v1 clears when it drains into stage 2 with no new accept.
  - out_valid clears when out_ready is high and stage 2 is not reloaded.
- Latency: accept at cycle t → out_valid at t+2 with no backpressure. Throughput is 1 sample/cycle.
- Hold: while out_valid && !out_ready, out_data is held stable. Stage 1 holds one further sample; with both stages full, in_ready=0.
- Warm-up: the delay line starts at zero, so:
  - first output = 13·x0;
  - second output = 13·x1 + 25·x0;
  - full FIR from the third output on.
- out_primed: 1 once sample_cnt ≥ 2.
- sample_cnt: increments on each accept and saturates at 2^CW−1; it never wraps.
- clear (priority over accept):
  - In that cycle: no accept; z1, w1, w2, v1, out_valid, sample_cnt and out_primed go to 0 next edge.
  - In-flight results are dropped; out_data keeps its last value but is invalid.
- Simultaneous accept and drain with both stages full and out_ready=1: stage 2 takes p1+q1 while stage 1 loads the new sample in the same edge; no bubble, no loss.
- Reset mid-operation: immediate return to reset state; the first post-reset sample is treated as x0.

Test Plan:
1. Reset; stream three triples (13,25,63) i.e. x=1, out_ready=1 → outputs 13, 38, 101, first at 2 cycles after the first accept; sample_cnt=3, out_primed=1 after the 2nd accept.
2. Impulse: x=1 triple then two x=0 triples then one more x=0 → outputs 13, 25, 63, 0.
3. Backpressure: in_valid=1 continuously with x=2 triples, out_ready=0 for 5 cycles → exactly 2 accepts then in_ready=0; out_data held at 26; after release, outputs 26, 76, 202 with no loss or duplication.
4. Overflow bound: three triples of 0xFFFFFFFF → third output 0x2FFFFFFFD, no truncation.
5. clear with one in flight and out_valid=1: the pending output is never presented, sample_cnt=0; next x=3 triple (39,75,189) → output 39, sample_cnt=1, out_primed=0.
6. Assert rst_n=0 asynchronously mid-stream between clock edges → out_valid and out_data go to 0 immediately; the first output after reset equals 13·x of the first new sample.
